z380_bus_cycle_ctrl: RTL and testbench



---
 rtl/z380_platform_pkg.sv | 16 +
 rtl/z380_wait_counter.sv | 44 ++++
 rtl/z380_bus_cycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_z380_bus_cycle_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/z380_platform_pkg.sv
// rtl/z380_platform_pkg.sv - shared types and constants for the Z380 external bus slice
package z380_platform_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    RESP   = 3'd5
  } bus_state_e;

  localparam int SETUP_CYCLES = 1;
  localparam int HOLD_CYCLES  = 1;

endpackage

// File: rtl/z380_wait_counter.sv
// rtl/z380_wait_counter.sv - programmed wait states plus WAIT_n extension and timeout
module z380_wait_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] wait_states,
  input  logic       active,
  input  logic       wait_n,
  output logic       done,
  output logic       timeout
);

  localparam int EXT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [EXT_W-1:0] EXT_MAX = EXT_W'(TIMEOUT_CYCLES);

  logic [3:0]       cnt_q;
  logic [EXT_W-1:0] ext_q;
  logic             prog_done;

  // Count down programmed waits, then count granted WAIT_n extension cycles (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ext_q <= '0;
    end else if (load) begin
      cnt_q <= wait_states;
      ext_q <= '0;
    end else if (active) begin
      if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end else if (!wait_n && ext_q != EXT_MAX) begin
        ext_q <= ext_q + 1'b1;
      end
    end
  end

  assign prog_done = (cnt_q == 4'd0);
  // The cycle in which ext_q already equals the limit is the last granted extension.
  assign done      = active && prog_done && wait_n;
  assign timeout   = active && prog_done && !wait_n && (ext_q == EXT_MAX);

endmodule

// File: rtl/z380_bus_cycle_ctrl.sv
// rtl/z380_bus_cycle_ctrl.sv - external bus cycle sequencer behind the chip-select decoder
module z380_bus_cycle_ctrl
  import z380_platform_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 16,
  parameter int RANGE_COUNT    = 4,
  parameter int INDEX_W        = (RANGE_COUNT < 2) ? 1 : $clog2(RANGE_COUNT),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic                   req_write,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_be,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_fault,
  output logic                   cs_addr_valid,
  output logic [ADDR_W-1:0]      cs_addr,
  input  logic                   cs_any,
  input  logic [INDEX_W-1:0]     cs_index,
  input  logic [3:0]             cs_wait_profile,
  output logic [ADDR_W-1:0]      ext_addr,
  output logic [RANGE_COUNT-1:0] ext_cs_n,
  output logic                   ext_rd_n,
  output logic                   ext_wr_n,
  output logic [DATA_W/8-1:0]    ext_be_n,
  output logic [DATA_W-1:0]      ext_wdata,
  output logic                   ext_data_oe,
  input  logic [DATA_W-1:0]      ext_rdata,
  input  logic                   ext_wait_n
);

  localparam int BE_W = DATA_W / 8;

  bus_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic             write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]  be_q;
  logic [3:0]       wprof_q;
  logic [DATA_W-1:0] rdata_q;
  logic             fault_q;
  logic             wc_done;
  logic             wc_timeout;
  logic [RANGE_COUNT-1:0] cs_onehot;

  assign req_ready     = (state_q == IDLE);
  assign cs_addr_valid = (state_q == DECODE);
  assign cs_addr       = addr_q;
  assign cs_onehot     = RANGE_COUNT'(1) << cs_index;

  z380_wait_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk         (clk),
    .rst         (rst),
    .load        (state_q == SETUP),
    .wait_states (wprof_q),
    .active      (state_q == STROBE),
    .wait_n      (ext_wait_n),
    .done        (wc_done),
    .timeout     (wc_timeout)
  );

  // Bus cycle sequencer; every ext_* and rsp_* output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      wprof_q     <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      ext_addr    <= '0;
      ext_cs_n    <= '1;
      ext_rd_n    <= 1'b1;
      ext_wr_n    <= 1'b1;
      ext_be_n    <= '1;
      ext_wdata   <= '0;
      ext_data_oe <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_fault   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (!cs_any) begin
            // Unmapped: no bus activity; the response is raised on the following cycle.
            rsp_fault <= 1'b1;
            rsp_rdata <= '0;
            state_q   <= RESP;
          end else begin
            wprof_q  <= cs_wait_profile;
            ext_cs_n <= ~cs_onehot;
            ext_addr <= addr_q;
            ext_be_n <= ~be_q;
            if (write_q) begin
              ext_wdata   <= wdata_q;
              ext_data_oe <= 1'b1;
            end
            rdata_q <= '0;
            fault_q <= 1'b0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          ext_rd_n <= write_q;
          ext_wr_n <= !write_q;
          state_q  <= STROBE;
        end
        STROBE: begin
          if (wc_done) begin
            if (!write_q) begin
              rdata_q <= ext_rdata;
            end
            ext_rd_n <= 1'b1;
            ext_wr_n <= 1'b1;
            state_q  <= HOLD;
          end else if (wc_timeout) begin
            fault_q  <= 1'b1;
            rdata_q  <= '0;
            ext_rd_n <= 1'b1;
            ext_wr_n <= 1'b1;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          ext_cs_n    <= '1;
          ext_be_n    <= '1;
          ext_data_oe <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= rdata_q;
          rsp_fault   <= fault_q;
          state_q     <= RESP;
        end
        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z380_bus_cycle_ctrl.sv
// tb/tb_z380_bus_cycle_ctrl.sv - directed self-checking bench for z380_bus_cycle_ctrl
module tb_z380_bus_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_fault;
  logic        cs_addr_valid;
  logic [31:0] cs_addr;
  logic        cs_any;
  logic [1:0]  cs_index;
  logic [3:0]  cs_wait_profile;
  logic [31:0] ext_addr;
  logic [3:0]  ext_cs_n;
  logic        ext_rd_n;
  logic        ext_wr_n;
  logic [1:0]  ext_be_n;
  logic [15:0] ext_wdata;
  logic        ext_data_oe;
  logic [15:0] ext_rdata;
  logic        ext_wait_n;

  int checks = 0;
  int errors = 0;

  int          lat, rd_low, wr_low, oe_cnt, cav_cnt;
  logic [3:0]  cs_seen;
  logic [1:0]  be_seen;
  logic [15:0] wdata_seen;
  logic [31:0] cav_addr, addr_seen;

  z380_bus_cycle_ctrl #(
    .ADDR_W(32), .DATA_W(16), .RANGE_COUNT(4), .INDEX_W(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .cs_addr_valid(cs_addr_valid), .cs_addr(cs_addr), .cs_any(cs_any),
    .cs_index(cs_index), .cs_wait_profile(cs_wait_profile),
    .ext_addr(ext_addr), .ext_cs_n(ext_cs_n), .ext_rd_n(ext_rd_n), .ext_wr_n(ext_wr_n),
    .ext_be_n(ext_be_n), .ext_wdata(ext_wdata), .ext_data_oe(ext_data_oe),
    .ext_rdata(ext_rdata), .ext_wait_n(ext_wait_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge and watch the bus until rsp_valid (bounded).
  // ext_wait_n is held low for strobe cycles wfrom .. wfrom+wlen-1 (1-based).
  task automatic run_req(input logic [31:0] addr, input logic wr, input logic [15:0] wd,
                         input logic [1:0] be, input int wfrom, input int wlen,
                         input logic [15:0] rdv);
    lat = -1; rd_low = 0; wr_low = 0; oe_cnt = 0; cav_cnt = 0;
    cs_seen = 4'hF; be_seen = 2'b11; wdata_seen = 16'h0; cav_addr = 32'h0; addr_seen = 32'h0;
    ext_wait_n = 1'b1;
    ext_rdata  = rdv;
    req_addr = addr; req_write = wr; req_wdata = wd; req_be = be; req_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (!ext_rd_n) rd_low++;
      if (!ext_wr_n) wr_low++;
      if (ext_data_oe) begin oe_cnt++; wdata_seen = ext_wdata; end
      if (ext_cs_n != 4'hF) begin cs_seen = ext_cs_n; addr_seen = ext_addr; end
      if (ext_be_n != 2'b11) be_seen = ext_be_n;
      if (cs_addr_valid) begin cav_cnt++; cav_addr = cs_addr; end
      ext_wait_n = ((rd_low + wr_low) >= wfrom && (rd_low + wr_low) < wfrom + wlen) ? 1'b0 : 1'b1;
      ext_rdata  = ext_wait_n ? rdv : 16'hDEAD;
      if (rsp_valid) begin
        lat = n - 1;
        break;
      end
    end
    ext_wait_n = 1'b1;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 1'b0);
    chk("req_ready_after_hs", req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    req_be = '0; rsp_ready = 1'b0; cs_any = 1'b0; cs_index = '0; cs_wait_profile = '0;
    ext_rdata = '0; ext_wait_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", ext_cs_n, 4'hF);
    chk("rst_rd_n", ext_rd_n, 1'b1);
    chk("rst_wr_n", ext_wr_n, 1'b1);
    chk("rst_be_n", ext_be_n, 2'b11);
    chk("rst_oe", ext_data_oe, 1'b0);
    chk("rst_addr", ext_addr, 32'h0);
    chk("rst_wdata", ext_wdata, 16'h0);
    chk("rst_rsp", {rsp_valid, rsp_fault, rsp_rdata}, 18'h0);
    rst = 1'b0;
    chk("idle_ready", req_ready, 1'b1);

    // Read, range 1, W=0, no wait
    cs_any = 1'b1; cs_index = 2'd1; cs_wait_profile = 4'd0;
    run_req(32'h0001_0040, 1'b0, 16'h0, 2'b11, 0, 0, 16'hBEEF);
    chk("rd0_cs", cs_seen, 4'b1101);
    chk("rd0_strobe", rd_low, 1);
    chk("rd0_wr", wr_low, 0);
    chk("rd0_oe", oe_cnt, 0);
    chk("rd0_lat", lat, 4);
    chk("rd0_rdata", rsp_rdata, 16'hBEEF);
    chk("rd0_fault", rsp_fault, 1'b0);
    chk("rd0_dec_cnt", cav_cnt, 1);
    chk("rd0_dec_addr", cav_addr, 32'h0001_0040);
    chk("rd0_ext_addr", addr_seen, 32'h0001_0040);
    handshake();

    // Write, range 2, W=3
    cs_index = 2'd2; cs_wait_profile = 4'd3;
    run_req(32'h0002_0010, 1'b1, 16'h1234, 2'b10, 0, 0, 16'h0);
    chk("wr3_cs", cs_seen, 4'b1011);
    chk("wr3_strobe", wr_low, 4);
    chk("wr3_rd", rd_low, 0);
    chk("wr3_be_n", be_seen, 2'b01);
    chk("wr3_oe", oe_cnt, 6);
    chk("wr3_wdata", wdata_seen, 16'h1234);
    chk("wr3_lat", lat, 7);
    chk("wr3_rdata", rsp_rdata, 16'h0);
    chk("wr3_fault", rsp_fault, 1'b0);
    handshake();

    // Read W=2, WAIT_n low for 5 cycles from the last programmed cycle
    cs_index = 2'd0; cs_wait_profile = 4'd2;
    run_req(32'h0000_0100, 1'b0, 16'h0, 2'b11, 3, 5, 16'hC0DE);
    chk("rdw_cs", cs_seen, 4'b1110);
    chk("rdw_strobe", rd_low, 8);
    chk("rdw_lat", lat, 11);
    chk("rdw_rdata", rsp_rdata, 16'hC0DE);
    chk("rdw_fault", rsp_fault, 1'b0);
    handshake();

    // Unmapped address
    cs_any = 1'b0;
    run_req(32'hFFFF_0000, 1'b0, 16'h0, 2'b11, 0, 0, 16'h7777);
    chk("um_cs", cs_seen, 4'hF);
    chk("um_strobes", rd_low + wr_low, 0);
    chk("um_lat", lat, 2);
    chk("um_fault", rsp_fault, 1'b1);
    chk("um_rdata", rsp_rdata, 16'h0);
    handshake();

    // Timeout: W=1, WAIT_n stuck low, TIMEOUT_CYCLES=8
    cs_any = 1'b1; cs_index = 2'd3; cs_wait_profile = 4'd1;
    run_req(32'h0003_0000, 1'b0, 16'h0, 2'b11, 2, 1000, 16'h4321);
    chk("to_strobe", rd_low, 10);
    chk("to_cs_hold", cs_seen, 4'b0111);
    chk("to_lat", lat, 13);
    chk("to_fault", rsp_fault, 1'b1);
    chk("to_rdata", rsp_rdata, 16'h0);
    handshake();

    // Reset pulsed mid-strobe, then a normal read
    cs_index = 2'd0; cs_wait_profile = 4'd5;
    req_addr = 32'h0000_0200; req_write = 1'b0; req_be = 2'b11; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 20 && ext_rd_n; n++) @(negedge clk);
    chk("rs_strobe_seen", ext_rd_n, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rs_rd_n", ext_rd_n, 1'b1);
    chk("rs_cs_n", ext_cs_n, 4'hF);
    chk("rs_rsp", rsp_valid, 1'b0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rs_no_rsp", rsp_valid, 1'b0);
    chk("rs_ready", req_ready, 1'b1);
    cs_index = 2'd3; cs_wait_profile = 4'd0;
    run_req(32'h0003_0008, 1'b0, 16'h0, 2'b11, 0, 0, 16'hA5A5);
    chk("rs_next_lat", lat, 4);
    chk("rs_next_rdata", rsp_rdata, 16'hA5A5);
    chk("rs_next_cs", cs_seen, 4'b0111);
    handshake();

    // Response back-pressure
    cs_index = 2'd1; cs_wait_profile = 4'd1;
    run_req(32'h0001_0002, 1'b0, 16'h0, 2'b11, 0, 0, 16'h5A5A);
    chk("bp_lat", lat, 5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_rdata", rsp_rdata, 16'h5A5A);
      chk("bp_fault", rsp_fault, 1'b0);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
